// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART receiver with mid-bit sampling, valid/ack holding
//            register, and sticky framing/overrun error flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_select,
    input  logic       rx_serial,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       busy
);

    localparam int                CNT_W      = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] C_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             oerr_q, oerr_d;
    logic             sync1_q, sync2_q;
    logic             w_rxs;

    assign w_rxs = sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            oerr_q  <= 1'b0;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            oerr_q  <= oerr_d;
            sync1_q <= rx_serial;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        oerr_d  = oerr_q;

        // Ack clears first so that a set in the same cycle wins for its flag.
        if (rx_ack) begin
            valid_d = 1'b0;
            ferr_d  = 1'b0;
            oerr_d  = 1'b0;
        end

        if (!uart_select) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    idx_d = '0;
                    if (!w_rxs) begin
                        state_d = S_START;
                    end
                end
                S_START: begin
                    if (cnt_q == C_HALF_LAST) begin
                        cnt_d   = '0;
                        state_d = w_rxs ? S_IDLE : S_DATA;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_q == C_BIT_LAST) begin
                        cnt_d   = '0;
                        shift_d = {w_rxs, shift_q[7:1]};
                        idx_d   = idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_d = S_STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (cnt_q == C_BIT_LAST) begin
                        cnt_d = '0;
                        if (w_rxs) begin
                            state_d = S_IDLE;
                            if (!valid_q || rx_ack) begin
                                data_d  = shift_q;
                                valid_d = 1'b1;
                            end else begin
                                oerr_d = 1'b1;
                            end
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = S_BREAK;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_BREAK: begin
                    if (w_rxs) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign frame_err   = ferr_q;
    assign overrun_err = oerr_q;
    assign busy        = (state_q != S_IDLE);

endmodule

`default_nettype wire
